// File: rtl/alu_result_stage.sv
// Result stage for the 16-bit ALU: selects one result word by opcode and queues it.
// Optional per-entry parity output when ALU_RESULT_STAGE_PARITY_EN is defined.
module alu_result_stage #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [255:0]     alu_bus,
    input  logic [3:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic             out_zr,
    output logic             out_ng,
    output logic [3:0]       out_op,
`ifdef ALU_RESULT_STAGE_PARITY_EN
    output logic             out_par,
`endif
    output logic [CNT_W-1:0] result_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] data;
        logic        zr;
        logic        ng;
`ifdef ALU_RESULT_STAGE_PARITY_EN
        logic        par;
`endif
    } entry_t;

    entry_t            mem_q [DEPTH];
    entry_t            mem_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CNT_W-1:0]  result_count_q, result_count_d;

    logic [15:0] sel_word;
    entry_t      new_entry;
    logic        push;
    logic        pop;

    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Word k sits at bits [16k+15:16k], so the base index is op * 16.
    assign sel_word = alu_bus[{op, 4'b0000} +: 16];

    always_comb begin
        new_entry      = '0;
        new_entry.op   = op;
        new_entry.data = sel_word;
        new_entry.zr   = (sel_word == 16'h0000);
        new_entry.ng   = sel_word[15];
`ifdef ALU_RESULT_STAGE_PARITY_EN
        new_entry.par  = ^sel_word;
`endif
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        result_count_d = result_count_q;
        if (push) begin
            mem_d[wr_ptr_q] = new_entry;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d       = rd_ptr_q + 1'b1;
            result_count_d = result_count_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            result_count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            result_count_q <= result_count_d;
        end
    end

    assign out_data     = mem_q[rd_ptr_q].data;
    assign out_zr       = mem_q[rd_ptr_q].zr;
    assign out_ng       = mem_q[rd_ptr_q].ng;
    assign out_op       = mem_q[rd_ptr_q].op;
`ifdef ALU_RESULT_STAGE_PARITY_EN
    assign out_par      = mem_q[rd_ptr_q].par;
`endif
    assign result_count = result_count_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: random and directed traffic against
// an ALU-level reference model; a negedge monitor compares the FIFO head.
module tb_alu_result_stage;

    localparam int DEPTH = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] alu_bus;
    logic [3:0]   op;
    logic         in_valid;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  out_data;
    logic         out_zr;
    logic         out_ng;
    logic [3:0]   out_op;
    logic [15:0]  result_count;
`ifdef ALU_RESULT_STAGE_PARITY_EN
    logic         out_par;
`endif

    alu_result_stage #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_bus      (alu_bus),
        .op           (op),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_zr       (out_zr),
        .out_ng       (out_ng),
        .out_op       (out_op),
`ifdef ALU_RESULT_STAGE_PARITY_EN
        .out_par      (out_par),
`endif
        .result_count (result_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Expected entries: {op, word}
    logic [19:0] exp_q[$];
    int unsigned exp_cnt = 0;
    bit          mon_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act,
                     exp, $time);
        end
    endtask

    // The ALU functions themselves, the "true" meaning of each word.
    function automatic logic [15:0] alu_fn(input int k, input logic [15:0] x,
                                           input logic [15:0] y, input bit d,
                                           input bit e);
        case (k)
            0:  return x + y;
            1:  return x - y;
            2:  return y - x;
            3:  return {15'd0, d};
            4:  return {15'd0, e};
            5:  return 16'hFFFF;
            6:  return -x;
            7:  return -y;
            8:  return ~x;
            9:  return ~y;
            10: return x + 16'd1;
            11: return y + 16'd1;
            12: return x - 16'd1;
            13: return y - 16'd1;
            14: return x & y;
            default: return x | y;
        endcase
    endfunction

    // One cycle: inputs driven at posedge+1, acceptance seen at negedge,
    // the expected entry recorded once the edge has taken it.
    task automatic cycle(input bit iv, input logic [3:0] o,
                         input logic [15:0] x, input logic [15:0] y,
                         input bit d, input bit e, input bit ordy);
        bit acc;
        logic [15:0] w;
        in_valid  = iv;
        op        = o;
        out_ready = ordy;
        for (int k = 0; k < 16; k++) begin
            alu_bus[16*k +: 16] = alu_fn(k, x, y, d, e);
        end
        w = alu_fn(int'(o), x, y, d, e);
        @(negedge clk);
        acc = iv && in_ready;
        @(posedge clk);
        if (acc) exp_q.push_back({o, w});
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            chk("in_ready", 32'(in_ready), 32'(exp_q.size() != DEPTH));
            chk("result_count", 32'(result_count), 32'(exp_cnt[15:0]));
            if (out_valid && exp_q.size() != 0) begin
                chk("out_data", 32'(out_data), 32'(exp_q[0][15:0]));
                chk("out_op", 32'(out_op), 32'(exp_q[0][19:16]));
                chk("out_zr", 32'(out_zr), 32'(exp_q[0][15:0] == 16'h0));
                chk("out_ng", 32'(out_ng), 32'(exp_q[0][15]));
`ifdef ALU_RESULT_STAGE_PARITY_EN
                chk("out_par", 32'(out_par), 32'(^exp_q[0][15:0]));
`endif
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    exp_cnt++;
                end
            end
        end
    end

    task automatic reset_now();
        rst = 1'b1;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_op", 32'(out_op), 32'd0);
        chk("rst_flags", {30'd0, out_zr, out_ng}, 32'd0);
        chk("rst_count", 32'(result_count), 32'd0);
`ifdef ALU_RESULT_STAGE_PARITY_EN
        chk("rst_out_par", 32'(out_par), 32'd0);
`endif
        exp_q.delete();
        exp_cnt = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = '0;
        alu_bus   = '0;
        @(posedge clk);
        #1;
        reset_now();
        mon_en = 1'b1;

        // Single push of 5, held, then popped.
        cycle(1, 4'd0, 16'h0005, 16'h0000, 0, 0, 0);
        cycle(0, 4'd0, 16'h0, 16'h0, 0, 0, 0);
        cycle(0, 4'd0, 16'h0, 16'h0, 0, 0, 1);
        // -5 via op 6, popped as soon as it appears.
        cycle(1, 4'd6, 16'h0005, 16'h0000, 0, 0, 1);
        cycle(0, 4'd0, 16'h0, 16'h0, 0, 0, 1);
        cycle(0, 4'd0, 16'h0, 16'h0, 0, 0, 1);
        chk("count_after_two", 32'(result_count), 32'd2);

        // Fill with 1, 0, then try 3 while full.
        cycle(1, 4'd0, 16'h0001, 16'h0, 0, 0, 0);
        cycle(1, 4'd0, 16'h0000, 16'h0, 0, 0, 0);
        cycle(1, 4'd0, 16'h0003, 16'h0, 0, 0, 0);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        cycle(0, 4'd0, 16'h0, 16'h0, 0, 0, 1);
        cycle(0, 4'd0, 16'h0, 16'h0, 0, 0, 1);
        cycle(0, 4'd0, 16'h0, 16'h0, 0, 0, 1);

        // count=1 with simultaneous push of AA and pop.
        cycle(1, 4'd0, 16'h0011, 16'h0, 0, 0, 0);
        cycle(1, 4'd0, 16'h00AA, 16'h0, 0, 0, 1);
        cycle(0, 4'd0, 16'h0, 16'h0, 0, 0, 0);
        chk("sim_head", 32'(out_data), 32'h00AA);
        cycle(0, 4'd0, 16'h0, 16'h0, 0, 0, 1);

        // Parity check word 7, all ops exercised with d/e set.
        cycle(1, 4'd0, 16'h0007, 16'h0, 0, 0, 1);
        for (int k = 0; k < 16; k++) begin
            cycle(1, 4'(k), 16'h8001, 16'h00F0, 1, 1, 1);
        end

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            cycle(bit'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  16'($urandom), 16'($urandom), bit'($urandom_range(0, 1)),
                  bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) != 0));
        end

        // Asynchronous reset with two entries held.
        cycle(1, 4'd0, 16'h1234, 16'h0, 0, 0, 0);
        cycle(1, 4'd0, 16'h5678, 16'h0, 0, 0, 0);
        cycle(0, 4'd0, 16'h0, 16'h0, 0, 0, 0);
        reset_now();

        // Stream until result_count reaches FFFF, then wrap once.
        cycle(1, 4'd0, 16'h0001, 16'h0, 0, 0, 0);
        for (int i = 0; i < 70000 && exp_cnt < 32'hFFFF; i++) begin
            cycle(1, 4'd0, 16'($urandom), 16'h0, 0, 0, 1);
        end
        cycle(1, 4'd0, 16'h0002, 16'h0, 0, 0, 0);
        chk("cnt_at_max", 32'(result_count), 32'h0000FFFF);
        cycle(0, 4'd0, 16'h0, 16'h0, 0, 0, 1);
        cycle(0, 4'd0, 16'h0, 16'h0, 0, 0, 0);
        chk("cnt_wrap", 32'(result_count), 32'h00000000);

        // Drain.
        for (int i = 0; i < 4; i++) begin
            cycle(0, 4'd0, 16'h0, 16'h0, 0, 0, 1);
        end
        chk("drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Downstream stage of the 16-bit ALU.
- Takes all sixteen ALU result words on one flat bus and selects one by opcode. Stores the selection with zero/negative status flags in a small FIFO and presents it to the consumer over a valid/ready handshake.
- Decouples the purely combinational ALU from a consumer that can stall (register writeback, display, UART).

Parameters:
DEPTH, 2, FIFO entries; power of two, >= 2.
CNT_W, 16, width of the delivered-result counter.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset.
alu_bus  input  256  ALU results; word k = bits [16k+15:16k]; k order: 0=a(x+y), 1=b(x-y), 2=c(y-x), 3=d, 4=e, 5=f(-1), 6=g(-x), 7=h(-y), 8=i(~x), 9=j(~y), 10=k(x+1), 11=l(y+1), 12=m(x-1), 13=n(y-1), 14=o(x&y), 15=p(x|y). 1-bit d/e are zero-extended to 16 bits by the instantiating level.
op  input  4  selects word k of alu_bus.
in_valid  input  1  upstream presents valid op/alu_bus.
in_ready  output  1  stage can accept.
out_valid  output  1  head entry valid.
out_ready  input  1  consumer accepts head.
out_data  output  16  head result word.
out_zr  output  1  head result == 16'h0000.
out_ng  output  1  head result bit 15.
out_op  output  4  opcode that produced the head entry.
result_count  output  CNT_W  number of entries popped since reset.

Behaviour:
- Push = in_valid & in_ready. On push, capture {op, alu_bus[16*op +: 16], zr, ng} into the tail entry. zr and ng are computed from the selected word at capture.
- Pop = out_valid & out_ready. On pop, advance the head pointer and increment result_count. result_count wraps from 2^CNT_W-1 to 0.
- Occupancy count is 0..DEPTH. Pointers are log2(DEPTH) bits and wrap naturally.
- in_ready = (count != DEPTH). It depends on count only; there is no combinational path from out_ready. When full, in_ready stays 0 even in a pop cycle.
- out_valid = (count != 0).
- out_data, out_zr, out_ng and out_op come from head storage, muxed directly from the register array.
- Latency: a push at edge N into an empty FIFO gives out_valid=1 with the data during cycle N+1. There is no bypass.
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged and ordering preserved.
- Push with count==0 and pop in the same cycle is impossible, because out_valid=0.
- Inputs are ignored when in_valid=0. op and alu_bus may change freely while in_valid=0.
- Upstream holds op/alu_bus stable while in_valid=1 and in_ready=0. The stage does not check this.
- Reset (asynchronous, any time, including mid-transfer):
  - pointers, count and result_count go to 0;
  - all storage goes to 0, so out_data=0, out_zr=0, out_ng=0, out_op=0;
  - out_valid=0 and in_ready=1 immediately.
  - A handshake in the reset cycle is discarded.
- After reset deasserts, the first push is accepted on the next rising edge.

Optional Feature:
- Macro: ALU_RESULT_STAGE_PARITY_EN.
- Defined: adds output out_par (1 bit), the even parity (XOR-reduce) of the selected word, stored per entry at push time. out_par resets to 0.
- Undefined: no out_par port and no parity storage. All other behaviour is identical.

Test Plan:
- Reset then alu_bus word0=16'h0005, op=0, in_valid one cycle -> next cycle out_valid=1, out_data=16'h0005, out_zr=0, out_ng=0, out_op=0.
- op=6 with word6=16'hFFFB (-5), out_ready=1 -> out_data=16'hFFFB, out_ng=1; pop on the same cycle; result_count 0->1; out_valid=0 on the following cycle.
- out_ready=0 with three back-to-back pushes of words 16'h0001, 16'h0000, 16'h0003 (DEPTH=2) -> in_ready=0 after the second push, third push not accepted. Then out_ready=1 -> pops 16'h0001 (zr=0), then 16'h0000 (zr=1); in_ready returns to 1 after the first pop.
- count=1 with simultaneous push 16'h00AA and pop -> count stays 1; next head=16'h00AA; no entry lost or duplicated.
- Assert rst mid-stream with 2 entries held -> out_valid=0, in_ready=1, out_data=0, result_count=0 without waiting for a clock edge.
- Preload result_count to 16'hFFFF via 65535 pops, then one more pop -> result_count=16'h0000. With ALU_RESULT_STAGE_PARITY_EN, word 16'h0007 -> out_par=1.
